// File: rtl/vga_driver.sv
// 640x480@60 VGA timing generator: sync pulses, coordinate requests,
// colour blanking and a per-frame tick with an 8-bit frame counter.
module vga_driver #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int V_TOTAL = 525
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic [11:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_en,
  output logic [11:0] vga_rgb,
  output logic        frame_tick,
  output logic [7:0]  frame_cnt
);

  localparam logic [9:0] L_H_SYNC = 10'(H_SYNC);
  localparam logic [9:0] L_V_SYNC = 10'(V_SYNC);
  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_HS     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] L_HE     = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] L_RS     = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] L_RE     = 10'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0] L_VS     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] L_VE     = 10'(V_SYNC + V_BACK + V_DISP);

  logic [9:0] r_cnt_h;
  logic [9:0] r_cnt_v;
  logic       r_frame_tick;
  logic [7:0] r_frame_cnt;

  logic w_h_end;
  logic w_v_end;
  logic w_v_act;
  logic w_h_act;
  logic w_h_req;
  logic w_req;
  logic w_en;

  assign w_h_end = (r_cnt_h == L_H_LAST);
  assign w_v_end = (r_cnt_v == L_V_LAST);

  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_cnt_h      <= '0;
      r_cnt_v      <= '0;
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_h_end) begin
        r_cnt_h <= '0;
        if (w_v_end) begin
          r_cnt_v      <= '0;
          r_frame_tick <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + 8'd1;
        end else begin
          r_cnt_v <= r_cnt_v + 10'd1;
        end
      end else begin
        r_cnt_h <= r_cnt_h + 10'd1;
      end
    end
  end

  assign w_v_act = (r_cnt_v >= L_VS) && (r_cnt_v < L_VE);
  assign w_h_act = (r_cnt_h >= L_HS) && (r_cnt_h < L_HE);
  // Request window runs one clock ahead to cover the colour-stage register
  assign w_h_req = (r_cnt_h >= L_RS) && (r_cnt_h < L_RE);
  assign w_req   = w_v_act && w_h_req;
  assign w_en    = w_v_act && w_h_act;

  assign vga_hs     = (r_cnt_h >= L_H_SYNC);
  assign vga_vs     = (r_cnt_v >= L_V_SYNC);
  assign vga_en     = w_en;
  assign data_req   = w_req;
  assign pixel_xpos = w_req ? (r_cnt_h - L_RS) : 10'd0;
  assign pixel_ypos = w_v_act ? (r_cnt_v - L_VS) : 10'd0;
  assign vga_rgb    = w_en ? pixel_data : 12'h000;
  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vga_driver.sv
// Directed bench: full-size instance for line timing and colour latency,
// reduced-size instance for frame, wrap and mid-frame reset behaviour.
module tb_vga_driver;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_b, rst_s, cmode;
  logic [11:0] pd_b, pd_s;
  logic [9:0]  b_x, b_y, s_x, s_y;
  logic        b_req, b_hs, b_vs, b_en, b_tick;
  logic        s_req, s_hs, s_vs, s_en, s_tick;
  logic [11:0] b_rgb, s_rgb;
  logic [7:0]  b_fc, s_fc;

  int vectors = 0;
  int errors  = 0;
  int bh = 0, bv = 0, sh = 0, sv = 0;

  vga_driver dut_b (
    .clk_25(clk), .rst(rst_b), .pixel_data(pd_b),
    .pixel_xpos(b_x), .pixel_ypos(b_y), .data_req(b_req),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_en(b_en), .vga_rgb(b_rgb),
    .frame_tick(b_tick), .frame_cnt(b_fc)
  );

  vga_driver #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2), .H_TOTAL(10),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1), .V_TOTAL(6)
  ) dut_s (
    .clk_25(clk), .rst(rst_s), .pixel_data(pd_s),
    .pixel_xpos(s_x), .pixel_ypos(s_y), .data_req(s_req),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_en(s_en), .vga_rgb(s_rgb),
    .frame_tick(s_tick), .frame_cnt(s_fc)
  );

  // colour stage: one-clock register of the requested coordinate
  always @(posedge clk)
    pd_b <= cmode ? {b_x[3:0], b_y[7:0]} : 12'hABC;
  assign pd_s = 12'hABC;

  always @(posedge clk) begin
    if (rst_b) begin bh <= 0; bv <= 0; end
    else if (bh == 799) begin bh <= 0; bv <= (bv == 524) ? 0 : bv + 1; end
    else bh <= bh + 1;
    if (rst_s) begin sh <= 0; sv <= 0; end
    else if (sh == 9) begin sh <= 0; sv <= (sv == 5) ? 0 : sv + 1; end
    else sh <= sh + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_b(input int h, input int v);
    int n = 0;
    while (!(bh == h && bv == v) && n < 40000) begin step(1); n++; end
    vectors++;
    if (!(bh == h && bv == v)) begin
      errors++; $display("FAIL wait_b timeout at h=%0d v=%0d", bh, bv);
    end
  endtask

  task automatic wait_s(input int h, input int v);
    int n = 0;
    while (!(sh == h && sv == v) && n < 1000) begin step(1); n++; end
    vectors++;
    if (!(sh == h && sv == v)) begin
      errors++; $display("FAIL wait_s timeout at h=%0d v=%0d", sh, sv);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b1; rst_s = 1'b1; cmode = 1'b0;
    step(3);
    rst_b = 1'b0; rst_s = 1'b0;
    vectors++;
    if ({b_hs, b_vs, b_en, b_req, b_tick} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 00000", {b_hs, b_vs, b_en, b_req, b_tick});
    end
    vectors++;
    if (b_rgb !== 12'h000 || b_fc !== 8'd0) begin
      errors++; $display("FAIL reset_rgb_fc got %h/%0d exp 000/0", b_rgb, b_fc);
    end
    vectors++;
    if (b_x !== 10'd0 || b_y !== 10'd0) begin
      errors++; $display("FAIL reset_pos got %0d/%0d exp 0/0", b_x, b_y);
    end
    step(95);
    vectors++;
    if (b_hs !== 1'b0) begin errors++; $display("FAIL hs_at95 got %b exp 0", b_hs); end
    step(1);
    vectors++;
    if (b_hs !== 1'b1) begin errors++; $display("FAIL hs_at96 got %b exp 1", b_hs); end
  endtask

  task automatic test_line_timing();
    int lows = 0, nr = 0;
    int rise [2];
    logic prev;
    wait_b(0, 1);
    prev = b_hs;
    for (int i = 0; i < 1600; i++) begin
      if (i < 800 && b_hs === 1'b0) lows++;
      if (i > 0 && prev === 1'b0 && b_hs === 1'b1 && nr < 2) begin rise[nr] = i; nr++; end
      prev = b_hs;
      step(1);
    end
    vectors++;
    if (lows != 96) begin errors++; $display("FAIL hs_low got %0d exp 96", lows); end
    vectors++;
    if (nr != 2 || rise[0] != 96 || rise[1] - rise[0] != 800) begin
      errors++; $display("FAIL hs_period got n=%0d r0=%0d r1=%0d exp 2/96/896", nr, rise[0], rise[1]);
    end
  endtask

  task automatic test_active_latency();
    int bad = 0;
    logic [11:0] e;
    cmode = 1'b1;
    wait_b(142, 35);
    vectors++;
    if (b_req !== 1'b0 || b_en !== 1'b0) begin
      errors++; $display("FAIL pre_req got req=%b en=%b exp 0/0", b_req, b_en);
    end
    step(1);
    vectors++;
    if (b_req !== 1'b1 || b_x !== 10'd0 || b_y !== 10'd0 || b_en !== 1'b0) begin
      errors++; $display("FAIL req_rise got req=%b x=%0d y=%0d en=%b exp 1/0/0/0", b_req, b_x, b_y, b_en);
    end
    step(1);
    vectors++;
    if (b_en !== 1'b1 || b_rgb !== 12'h000 || b_x !== 10'd1) begin
      errors++; $display("FAIL en_rise got en=%b rgb=%h x=%0d exp 1/000/1", b_en, b_rgb, b_x);
    end
    for (int h = 145; h <= 784; h++) begin
      step(1);
      if (h <= 783) begin
        e = {4'(h - 144), 8'h00};
        vectors++;
        if (b_en !== 1'b1 || b_rgb !== e) begin
          errors++; bad++;
          if (bad < 5) $display("FAIL latency h=%0d got en=%b rgb=%h exp 1/%h", h, b_en, b_rgb, e);
        end
      end
      if (h == 782) begin
        vectors++;
        if (b_x !== 10'd639 || b_req !== 1'b1) begin
          errors++; $display("FAIL last_x got x=%0d req=%b exp 639/1", b_x, b_req);
        end
      end
      if (h == 783) begin
        vectors++;
        if (b_req !== 1'b0 || b_x !== 10'd0) begin
          errors++; $display("FAIL req_fall got req=%b x=%0d exp 0/0", b_req, b_x);
        end
      end
      if (h == 784) begin
        vectors++;
        if (b_en !== 1'b0 || b_rgb !== 12'h000) begin
          errors++; $display("FAIL en_fall got en=%b rgb=%h exp 0/000", b_en, b_rgb);
        end
      end
    end
  endtask

  task automatic test_blanking();
    cmode = 1'b0;
    wait_b(100, 36);
    vectors++;
    if (b_en !== 1'b0 || b_rgb !== 12'h000) begin
      errors++; $display("FAIL blank_h100 got en=%b rgb=%h exp 0/000", b_en, b_rgb);
    end
    wait_b(300, 36);
    vectors++;
    if (b_en !== 1'b1 || b_rgb !== 12'hABC || b_y !== 10'd1 || b_x !== 10'd157) begin
      errors++; $display("FAIL vis_h300 got en=%b rgb=%h y=%0d x=%0d exp 1/abc/1/157", b_en, b_rgb, b_y, b_x);
    end
  endtask

  task automatic test_frame();
    int nt = 0, nv = 0, vlow = 0;
    int tk [3];
    int vr [3];
    logic prev;
    rst_s = 1'b1;
    step(1);
    rst_s = 1'b0;
    vectors++;
    if (s_tick !== 1'b0 || s_fc !== 8'd0 || s_vs !== 1'b0) begin
      errors++; $display("FAIL s_reset got tick=%b fc=%0d vs=%b exp 0/0/0", s_tick, s_fc, s_vs);
    end
    prev = s_vs;
    for (int k = 1; k <= 180; k++) begin
      step(1);
      if (s_tick === 1'b1 && nt < 3) begin tk[nt] = k; nt++; end
      if (s_vs === 1'b0) vlow++;
      if (prev === 1'b0 && s_vs === 1'b1 && nv < 3) begin vr[nv] = k; nv++; end
      prev = s_vs;
      if (sv == 2 && sh == 0) begin
        vectors++;
        if (s_y !== 10'd0) begin errors++; $display("FAIL s_ytop got %0d exp 0", s_y); end
      end
      if (sv == 4 && sh == 0) begin
        vectors++;
        if (s_y !== 10'd2) begin errors++; $display("FAIL s_ybot got %0d exp 2", s_y); end
      end
      if (sv == 5 && sh == 5) begin
        vectors++;
        if (s_en !== 1'b0 || s_rgb !== 12'h000) begin
          errors++; $display("FAIL s_blank_fp got en=%b rgb=%h exp 0/000", s_en, s_rgb);
        end
      end
      if (sv == 3 && sh == 5) begin
        vectors++;
        if (s_en !== 1'b1 || s_rgb !== 12'hABC) begin
          errors++; $display("FAIL s_visible got en=%b rgb=%h exp 1/abc", s_en, s_rgb);
        end
      end
    end
    vectors++;
    if (nt != 3 || tk[0] != 60 || tk[1] != 120 || tk[2] != 180) begin
      errors++; $display("FAIL s_ticks got n=%0d %0d %0d %0d exp 3 60 120 180", nt, tk[0], tk[1], tk[2]);
    end
    vectors++;
    if (vlow != 30 || nv != 3 || vr[0] != 10 || vr[1] - vr[0] != 60) begin
      errors++; $display("FAIL s_vs got low=%0d n=%0d r0=%0d r1=%0d exp 30/3/10/70", vlow, nv, vr[0], vr[1]);
    end
    vectors++;
    if (s_fc !== 8'd3) begin errors++; $display("FAIL s_fc3 got %0d exp 3", s_fc); end
  endtask

  task automatic test_wrap();
    step(15119);
    vectors++;
    if (s_fc !== 8'd254 || s_tick !== 1'b0) begin
      errors++; $display("FAIL s_fc254 got %0d tick=%b exp 254/0", s_fc, s_tick);
    end
    step(1);
    vectors++;
    if (s_fc !== 8'd255 || s_tick !== 1'b1) begin
      errors++; $display("FAIL s_fc255 got %0d tick=%b exp 255/1", s_fc, s_tick);
    end
    step(60);
    vectors++;
    if (s_fc !== 8'd0 || s_tick !== 1'b1) begin
      errors++; $display("FAIL s_fc_wrap got %0d tick=%b exp 0/1", s_fc, s_tick);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    wait_s(6, 3);
    rst_s = 1'b1;
    step(1);
    rst_s = 1'b0;
    vectors++;
    if ({s_hs, s_vs, s_tick, s_en} !== 4'b0 || s_fc !== 8'd0 || s_y !== 10'd0) begin
      errors++; $display("FAIL mid_rst got hs=%b vs=%b tick=%b en=%b fc=%0d y=%0d exp all 0",
                         s_hs, s_vs, s_tick, s_en, s_fc, s_y);
    end
    do begin step(1); n++; end while (s_tick !== 1'b1 && n < 200);
    vectors++;
    if (n != 60 || s_fc !== 8'd1) begin
      errors++; $display("FAIL mid_rst_frame got len=%0d fc=%0d exp 60/1", n, s_fc);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_active_latency();
    test_blanking();
    test_frame();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
